// File: rtl/branch_sequencer_if.sv
// Sequencer-side bus: instruction fetch, BLU branch handshake and datapath execute handshake.
interface branch_sequencer_if #(
   parameter int unsigned PC_WIDTH = 16
);
   logic [PC_WIDTH-1:0] PC;
   logic                InstrReq;
   logic                InstrValid;
   logic [15:0]         Instr;
   logic                BranchCycle;
   logic [1:0]          BranchCond;
   logic                DoBranch;
   logic                ExecStart;
   logic                ExecDone;
   logic [15:0]         IR;
   logic                Halted;

   modport master (
      output PC, InstrReq, BranchCycle, BranchCond, ExecStart, IR, Halted,
      input  InstrValid, Instr, DoBranch, ExecDone
   );

   modport slave (
      input  PC, InstrReq, BranchCycle, BranchCond, ExecStart, IR, Halted,
      output InstrValid, Instr, DoBranch, ExecDone
   );
endinterface

// File: rtl/branch_sequencer.sv
// Instruction sequencer: owns the PC, fetches, decodes branch vs. non-branch,
// drives the BLU branch cycle and hands non-branch instructions to the datapath.
module branch_sequencer #(
   parameter int unsigned         PC_WIDTH   = 16,
   parameter logic [PC_WIDTH-1:0] RESET_PC   = '0,
   parameter logic [1:0]          BRANCH_OP  = 2'b11,
   parameter logic [15:0]         HALT_INSTR = 16'h0000
) (
   input  logic                Clk,
   input  logic                Reset_n,
   branch_sequencer_if.master  bus
);

   localparam int unsigned ST_W = 3;

   localparam logic [ST_W-1:0] S_FETCH  = 3'd0;
   localparam logic [ST_W-1:0] S_DECODE = 3'd1;
   localparam logic [ST_W-1:0] S_BRANCH = 3'd2;
   localparam logic [ST_W-1:0] S_EXEC   = 3'd3;
   localparam logic [ST_W-1:0] S_HALT   = 3'd4;

   logic [ST_W-1:0]     state_q, state_d;
   logic [PC_WIDTH-1:0] pc_q, pc_d;
   logic [15:0]         ir_q, ir_d;
   logic                instr_req_q, instr_req_d;
   logic                branch_cycle_q, branch_cycle_d;
   logic [1:0]          branch_cond_q, branch_cond_d;
   logic                exec_start_q, exec_start_d;
   logic                halted_q, halted_d;
   logic [PC_WIDTH-1:0] branch_off;

   // 12-bit PC-relative offset, sign-extended to the PC width.
   assign branch_off = PC_WIDTH'($signed(ir_q[11:0]));

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q        <= S_FETCH;
         pc_q           <= RESET_PC;
         ir_q           <= '0;
         instr_req_q    <= 1'b0;
         branch_cycle_q <= 1'b0;
         branch_cond_q  <= 2'b00;
         exec_start_q   <= 1'b0;
         halted_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         pc_q           <= pc_d;
         ir_q           <= ir_d;
         instr_req_q    <= instr_req_d;
         branch_cycle_q <= branch_cycle_d;
         branch_cond_q  <= branch_cond_d;
         exec_start_q   <= exec_start_d;
         halted_q       <= halted_d;
      end
   end

   // Next state; InstrReq is re-armed on every return to FETCH so a
   // memory with immediate valid gives a one-cycle fetch.
   always_comb begin
      state_d        = state_q;
      pc_d           = pc_q;
      ir_d           = ir_q;
      instr_req_d    = 1'b0;
      branch_cycle_d = 1'b0;
      branch_cond_d  = 2'b00;
      exec_start_d   = 1'b0;
      halted_d       = halted_q;

      case (state_q)
         S_FETCH: begin
            if (instr_req_q && bus.InstrValid) begin
               ir_d    = bus.Instr;
               state_d = S_DECODE;
            end else begin
               instr_req_d = 1'b1;
            end
         end
         S_DECODE: begin
            if (ir_q == HALT_INSTR) begin
               state_d  = S_HALT;
               halted_d = 1'b1;
            end else if (ir_q[15:14] == BRANCH_OP) begin
               state_d        = S_BRANCH;
               branch_cycle_d = 1'b1;
               branch_cond_d  = ir_q[13:12];
            end else begin
               state_d      = S_EXEC;
               exec_start_d = 1'b1;
            end
         end
         S_BRANCH: begin
            pc_d        = bus.DoBranch ? pc_q + branch_off : pc_q + PC_WIDTH'(1);
            state_d     = S_FETCH;
            instr_req_d = 1'b1;
         end
         S_EXEC: begin
            if (bus.ExecDone) begin
               pc_d        = pc_q + PC_WIDTH'(1);
               state_d     = S_FETCH;
               instr_req_d = 1'b1;
            end
         end
         S_HALT: begin
            state_d = S_HALT;
         end
         default: begin
            state_d = S_FETCH;
         end
      endcase
   end

   assign bus.PC          = pc_q;
   assign bus.InstrReq    = instr_req_q;
   assign bus.BranchCycle = branch_cycle_q;
   assign bus.BranchCond  = branch_cond_q;
   assign bus.ExecStart   = exec_start_q;
   assign bus.IR          = ir_q;
   assign bus.Halted      = halted_q;

endmodule

// File: tb/tb_branch_sequencer.sv
// Bench for branch_sequencer: directed and randomized instruction streams
// checked against an instruction-level PC model.
module tb_branch_sequencer;

   logic clk   = 1'b0;
   logic rst_n = 1'b0;
   int   vectors = 0;
   int   errors  = 0;
   logic [15:0] model_pc;

   branch_sequencer_if #(.PC_WIDTH(16)) bus ();

   branch_sequencer #(
      .PC_WIDTH(16), .RESET_PC(16'h0000), .BRANCH_OP(2'b11), .HALT_INSTR(16'h0000)
   ) dut (
      .Clk(clk), .Reset_n(rst_n), .bus(bus)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      bus.InstrValid = 1'b0; bus.Instr = 16'h0; bus.DoBranch = 1'b0; bus.ExecDone = 1'b0;
      rst_n = 1'b0;
      step();
      step();
      rst_n    = 1'b1;
      model_pc = 16'h0000;
   endtask

   // Expected PC after an instruction, from the architectural rules.
   function automatic logic [15:0] next_pc(input logic [15:0] pc, input logic [15:0] instr,
                                           input logic taken);
      int off;
      off = int'(instr[11:0]);
      if (off >= 2048) off -= 4096;
      if (instr[15:14] == 2'b11 && taken) return 16'((int'(pc) + off) & 32'hFFFF);
      return 16'((int'(pc) + 1) & 32'hFFFF);
   endfunction

   // Runs one instruction through fetch/decode/branch-or-exec and checks every phase.
   task automatic run_instr(input logic [15:0] instr, input int vdelay, input logic taken,
                            input int ddelay);
      int          guard;
      logic [15:0] exp_pc;
      guard = 0;
      while (bus.InstrReq !== 1'b1 && guard < 10) begin step(); guard++; end
      vectors++;
      if (bus.InstrReq !== 1'b1) begin errors++; $display("FAIL fetch_req timeout got=%b want=1", bus.InstrReq); end
      vectors++;
      if (bus.PC !== model_pc) begin errors++; $display("FAIL fetch_pc got=%h want=%h", bus.PC, model_pc); end
      for (int i = 0; i < vdelay; i++) begin
         bus.DoBranch = 1'($urandom); bus.ExecDone = 1'($urandom); bus.Instr = 16'($urandom);
         step();
         vectors++;
         if ({bus.InstrReq, bus.PC, bus.BranchCycle, bus.ExecStart} !== {1'b1, model_pc, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL fetch_stall req/pc/bc/es got=%b/%h/%b/%b want=1/%h/0/0",
                     bus.InstrReq, bus.PC, bus.BranchCycle, bus.ExecStart, model_pc);
         end
      end
      bus.DoBranch = 1'b0; bus.ExecDone = 1'b0; bus.InstrValid = 1'b1; bus.Instr = instr;
      step();
      bus.InstrValid = 1'b0; bus.Instr = 16'($urandom);
      vectors++;
      if ({bus.IR, bus.InstrReq, bus.BranchCycle, bus.ExecStart} !== {instr, 1'b0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL decode ir/req/bc/es got=%h/%b/%b/%b want=%h/0/0/0",
                  bus.IR, bus.InstrReq, bus.BranchCycle, bus.ExecStart, instr);
      end
      step();
      if (instr == 16'h0000) begin
         for (int i = 0; i < 20; i++) begin
            vectors++;
            if ({bus.Halted, bus.InstrReq, bus.PC} !== {1'b1, 1'b0, model_pc}) begin
               errors++;
               $display("FAIL halt halted/req/pc got=%b/%b/%h want=1/0/%h", bus.Halted, bus.InstrReq, bus.PC, model_pc);
            end
            bus.InstrValid = 1'($urandom); bus.DoBranch = 1'($urandom); bus.ExecDone = 1'($urandom);
            step();
         end
         bus.InstrValid = 1'b0; bus.DoBranch = 1'b0; bus.ExecDone = 1'b0;
         return;
      end
      exp_pc = next_pc(model_pc, instr, taken);
      if (instr[15:14] == 2'b11) begin
         vectors++;
         if ({bus.BranchCycle, bus.BranchCond, bus.PC, bus.ExecStart} !== {1'b1, instr[13:12], model_pc, 1'b0}) begin
            errors++;
            $display("FAIL branch_cycle bc/cond/pc/es got=%b/%b/%h/%b want=1/%b/%h/0",
                     bus.BranchCycle, bus.BranchCond, bus.PC, bus.ExecStart, instr[13:12], model_pc);
         end
         bus.DoBranch = taken;
         step();
         bus.DoBranch = 1'b0;
      end else begin
         for (int k = 0; k <= ddelay; k++) begin
            bus.ExecDone = (k == ddelay);
            bus.DoBranch = 1'($urandom);
            vectors++;
            if ({bus.ExecStart, bus.PC, bus.BranchCycle} !== {(k == 0), model_pc, 1'b0}) begin
               errors++;
               $display("FAIL exec k=%0d es/pc/bc got=%b/%h/%b want=%b/%h/0",
                        k, bus.ExecStart, bus.PC, bus.BranchCycle, (k == 0), model_pc);
            end
            step();
         end
         bus.ExecDone = 1'b0; bus.DoBranch = 1'b0;
      end
      vectors++;
      if ({bus.PC, bus.InstrReq, bus.BranchCycle, bus.BranchCond, bus.ExecStart} !== {exp_pc, 1'b1, 1'b0, 2'b00, 1'b0}) begin
         errors++;
         $display("FAIL retire pc/req/bc/cond/es got=%h/%b/%b/%b/%b want=%h/1/0/00/0",
                  bus.PC, bus.InstrReq, bus.BranchCycle, bus.BranchCond, bus.ExecStart, exp_pc);
      end
      model_pc = exp_pc;
   endtask

   task automatic test_reset();
      bus.InstrValid = 1'b1; bus.Instr = 16'hC005; bus.DoBranch = 1'b1; bus.ExecDone = 1'b1;
      rst_n = 1'b0;
      #3;
      for (int i = 0; i < 3; i++) begin
         vectors++;
         if ({bus.PC, bus.IR, bus.InstrReq, bus.BranchCycle, bus.BranchCond, bus.ExecStart, bus.Halted} !== 38'h0) begin
            errors++;
            $display("FAIL reset_state pc/ir/req/bc/cond/es/h got=%h/%h/%b/%b/%b/%b/%b want=0",
                     bus.PC, bus.IR, bus.InstrReq, bus.BranchCycle, bus.BranchCond, bus.ExecStart, bus.Halted);
         end
         step();
      end
      bus.InstrValid = 1'b0; bus.DoBranch = 1'b0; bus.ExecDone = 1'b0;
      rst_n    = 1'b1;
      model_pc = 16'h0000;
      vectors++;
      if (bus.InstrReq !== 1'b0) begin errors++; $display("FAIL reset_release_req got=%b want=0", bus.InstrReq); end
      step();
      vectors++;
      if (bus.InstrReq !== 1'b1) begin errors++; $display("FAIL first_req got=%b want=1", bus.InstrReq); end
   endtask

   task automatic test_basic_exec();
      run_instr(16'h1234, 0, 1'b0, 0);
   endtask

   task automatic test_branch_taken_not_taken();
      run_instr(16'hC00F, 0, 1'b1, 0);
      run_instr(16'hC005, 0, 1'b1, 0);
      run_instr(16'hCFFB, 0, 1'b1, 0);
      run_instr(16'hC005, 0, 1'b0, 0);
   endtask

   task automatic test_branch_wrap();
      do_reset();
      run_instr(16'h1234, 0, 1'b0, 0);
      run_instr(16'hEFFE, 0, 1'b1, 0);
   endtask

   task automatic test_exec_wrap();
      run_instr(16'h4321, 0, 1'b0, 4);
   endtask

   task automatic test_fetch_stall();
      run_instr(16'h2222, 5, 1'b0, 1);
      run_instr(16'hD010, 5, 1'b1, 0);
   endtask

   task automatic test_random();
      logic [15:0] instr;
      for (int n = 0; n < 60; n++) begin
         instr = 16'($urandom);
         if ($urandom_range(0, 1) == 1) instr[15:14] = 2'b11;
         if (instr == 16'h0000) instr = 16'h0001;
         run_instr(instr, $urandom_range(0, 3), 1'($urandom), $urandom_range(0, 3));
      end
      run_instr(16'hF000, 0, 1'b1, 0);
   endtask

   task automatic test_halt();
      run_instr(16'h0000, 1, 1'b0, 0);
   endtask

   task automatic test_reset_mid_branch();
      int guard;
      do_reset();
      run_instr(16'h5A5A, 0, 1'b0, 2);
      guard = 0;
      while (bus.InstrReq !== 1'b1 && guard < 10) begin step(); guard++; end
      bus.InstrValid = 1'b1; bus.Instr = 16'hD123;
      step();
      bus.InstrValid = 1'b0;
      step();
      bus.DoBranch = 1'b1;
      vectors++;
      if (bus.BranchCycle !== 1'b1) begin errors++; $display("FAIL mid_branch_reach got=%b want=1", bus.BranchCycle); end
      rst_n = 1'b0;
      #2;
      vectors++;
      if ({bus.PC, bus.IR, bus.InstrReq, bus.BranchCycle, bus.BranchCond, bus.ExecStart, bus.Halted} !== 38'h0) begin
         errors++;
         $display("FAIL async_reset pc/ir/req/bc/cond/es/h got=%h/%h/%b/%b/%b/%b/%b want=0",
                  bus.PC, bus.IR, bus.InstrReq, bus.BranchCycle, bus.BranchCond, bus.ExecStart, bus.Halted);
      end
      bus.DoBranch = 1'b0;
      step();
      rst_n    = 1'b1;
      model_pc = 16'h0000;
      run_instr(16'h1111, 0, 1'b0, 0);
   endtask

   initial begin
      bus.InstrValid = 1'b0; bus.Instr = 16'h0; bus.DoBranch = 1'b0; bus.ExecDone = 1'b0;
      model_pc = 16'h0000;
      test_reset();
      test_basic_exec();
      test_branch_taken_not_taken();
      test_branch_wrap();
      test_exec_wrap();
      test_fetch_stall();
      test_random();
      test_halt();
      test_reset_mid_branch();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule

// File: doc/branch_sequencer.md
Name: branch_sequencer

Overview:
Instruction sequencer that owns the program counter and drives the BLU branch interface: fetches a 16-bit instruction, decodes branch vs. non-branch, and for branches raises BranchCycle/BranchCond for one cycle. It samples the BLU's DoBranch and selects the next PC: taken gives PC-relative target, not-taken gives PC+1. Sits between instruction memory, BLU and the datapath execute stage.

Parameters:
PC_WIDTH, 16, program counter / address width
RESET_PC, 16'h0000, PC value loaded on reset
BRANCH_OP, 2'b11, value of Instr[15:14] marking a branch instruction
HALT_INSTR, 16'h0000, instruction encoding that halts the sequencer

Ports:
Clk  input  1  clock, rising-edge
Reset_n  input  1  asynchronous active-low reset
PC  output  PC_WIDTH  current program counter / fetch address
InstrReq  output  1  fetch request, held high in FETCH
InstrValid  input  1  instruction memory returns Instr this cycle
Instr  input  16  fetched instruction word
BranchCycle  output  1  to BLU: branch evaluation cycle
BranchCond  output  2  to BLU: 00 bin, 01 bifz, 10 binz, 11 bip
DoBranch  input  1  from BLU: branch taken (combinational from BranchCycle/BranchCond/Acc)
ExecStart  output  1  one-cycle pulse: datapath executes IR
ExecDone  input  1  datapath finished current instruction
IR  output  16  registered instruction for the datapath
Halted  output  1  sequencer stopped on HALT_INSTR

Behaviour:
- Reset (async, Reset_n=0): state=FETCH, PC=RESET_PC, IR=0, InstrReq=0, BranchCycle=0, BranchCond=00, ExecStart=0, Halted=0. InstrReq asserts on the first clock edge after release. Mid-operation reset aborts any state immediately. No pending outputs survive.
- All outputs are registered. No combinational path from inputs to outputs.
- States: FETCH, DECODE, BRANCH, EXEC, HALT.
- FETCH: InstrReq=1, PC stable. On the edge where InstrValid=1: IR<=Instr, InstrReq<=0, go to DECODE. Otherwise stay in FETCH indefinitely. InstrValid is ignored in all other states.
- DECODE (1 cycle): evaluated in priority order.
  - IR==HALT_INSTR: go to HALT.
  - IR[15:14]==BRANCH_OP: go to BRANCH, registering BranchCycle<=1 and BranchCond<=IR[13:12].
  - Otherwise: go to EXEC with ExecStart<=1.
- BRANCH (exactly 1 cycle): BranchCycle=1, BranchCond stable for the whole cycle. DoBranch is sampled at the closing edge.
  - Taken: PC<=PC+sext(IR[11:0]), offset relative to the branch's own PC.
  - Not taken: PC<=PC+1.
  - Then BranchCycle<=0, BranchCond<=00, go to FETCH.
  - DoBranch is ignored outside BRANCH.
- EXEC: ExecStart is high only in the first EXEC cycle. Wait for ExecDone=1, which may arrive in the same cycle as ExecStart. Then PC<=PC+1 and go to FETCH. ExecDone is ignored outside EXEC.
- HALT: Halted=1, InstrReq=0, PC frozen. Only reset exits.
- Arithmetic: 12-bit offset sign-extended to PC_WIDTH. All PC arithmetic is modulo 2^PC_WIDTH (wraps FFFF->0000 and 0000-1->FFFF). Offset 0 taken gives a self-loop, which is legal.
- Minimum instruction latency: branch 3 cycles (FETCH with immediate valid, DECODE, BRANCH); non-branch 3 cycles.

Test Plan:
- Reset release, memory returns 16'h1234 (non-branch) with InstrValid on the first request, ExecDone=1 immediately -> InstrReq high at PC=0000; DECODE; ExecStart 1-cycle pulse; next fetch at PC=0001.
- PC=0010, Instr=16'hC005 (bin, +5), DoBranch=1 -> BranchCycle=1 and BranchCond=00 for exactly one cycle; next PC=0015. Repeat with DoBranch=0 -> PC=0011.
- Instr=16'hEFFE (binz, offset -2) at PC=0001, DoBranch=1 -> PC=FFFF (wrap); BranchCond=10 during BRANCH.
- PC=FFFF, non-branch instruction, ExecDone delayed 4 cycles -> ExecStart pulses once, PC holds FFFF until ExecDone, then PC=0000.
- InstrValid withheld 5 cycles -> InstrReq and PC held stable; a DoBranch=1 and ExecDone pulse injected during FETCH have no effect.
- Instr=16'h0000 -> Halted=1, InstrReq stays 0 for 20 cycles. Then assert Reset_n=0 mid-BRANCH on a later run -> all outputs reset asynchronously before the next edge and PC=RESET_PC.
